// File: rtl/gate_reduce_stream_pkg.sv
// Shared definitions for the streaming reduce gate: FSM states and gate mode codes.
// The mode codes are also used by the bench and by the other gate blocks.
package gate_reduce_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] GATE_AND     = 3'd0;
  localparam logic [2:0] GATE_OR      = 3'd1;
  localparam logic [2:0] GATE_XOR     = 3'd2;
  localparam logic [2:0] GATE_NAND    = 3'd3;
  localparam logic [2:0] GATE_NOR     = 3'd4;
  localparam logic [2:0] GATE_XNOR    = 3'd5;
  // Highest legal mode code; anything above is reserved.
  localparam logic [2:0] GATE_RSV_LIM = 3'd5;

endpackage

// File: rtl/gate_reduce_stream_op_unit.sv
// Combinational two-input base gate: the non-inverted fold operator for each mode.
// Inverting modes share the operator of their base gate; reserved modes yield zero.
module gate_op_unit
  import gate_reduce_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (mode)
      GATE_AND, GATE_NAND: y = a & b;
      GATE_OR,  GATE_NOR:  y = a | b;
      GATE_XOR, GATE_XNOR: y = a ^ b;
      default:             y = '0;
    endcase
  end

endmodule

// File: rtl/gate_reduce_stream.sv
// Streaming N-operand bitwise reduce gate with valid/ready input and output.
// Folds NUM_OPERANDS beats with the mode latched on the first beat, then holds one result.
module gate_reduce_stream
  import gate_reduce_stream_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int NUM_OPERANDS = 4,
  parameter int CNT_W        = $clog2(NUM_OPERANDS) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       mode,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_mode_q;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_err;
  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_fold;

  // Inversion happens once on the final value; reserved modes force zero.
  function automatic logic [WIDTH-1:0] finalize(input logic [2:0] m, input logic [WIDTH-1:0] v);
    if (m > GATE_RSV_LIM)
      return '0;
    else if (m == GATE_NAND || m == GATE_NOR || m == GATE_XNOR)
      return ~v;
    else
      return v;
  endfunction

  gate_op_unit #(.WIDTH(WIDTH)) u_op (
    .mode (r_mode_q),
    .a    (r_acc),
    .b    (in_data),
    .y    (w_fold)
  );

  assign in_ready  = rst_n && !abort && (r_state != S_DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_state == S_ACCUM) && (r_cnt == CNT_W'(NUM_OPERANDS - 1));
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept) w_state_nxt = S_ACCUM;
        S_ACCUM: if (w_accept && w_last) w_state_nxt = S_DONE;
        S_DONE:  if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mode_q    <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else if (abort) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_acc    <= in_data;
            r_mode_q <= mode;
            r_cnt    <= CNT_W'(1);
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_acc <= w_fold;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_out_data  <= finalize(r_mode_q, w_fold);
              r_out_err   <= (r_mode_q > GATE_RSV_LIM);
              r_out_valid <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (r_out_valid && out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_reduce_stream.sv
// Directed bench for gate_reduce_stream (WIDTH=8, NUM_OPERANDS=4) with hand-computed results.
module tb_gate_reduce_stream;
  import gate_reduce_stream_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] mode;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  gate_reduce_stream #(.WIDTH(8), .NUM_OPERANDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [2:0] m);
    in_valid = 1'b1;
    in_data  = d;
    mode     = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h exp 00", out_data); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b exp 0", out_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_nor();
    out_ready = 1'b1;
    send(8'h01, GATE_NOR);
    send(8'h02, GATE_AND);
    send(8'h04, GATE_AND);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nor_early_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nor_busy got %b exp 1", busy); end
    send(8'h08, GATE_AND);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nor_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 8'hF0) begin errors++; $display("FAIL nor_data got %h exp f0", out_data); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL nor_err got %b exp 0", out_err); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nor_valid_one_cycle got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nor_back_idle got %b exp 0", busy); end
  endtask

  task automatic test_xor_backpressure();
    out_ready = 1'b0;
    send(8'hFF, GATE_XOR);
    send(8'h0F, GATE_XOR);
    send(8'hF0, GATE_XOR);
    send(8'h00, GATE_XOR);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL xor_hold_valid[%0d] got %b exp 1", i, out_valid); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL xor_hold_data[%0d] got %h exp 00", i, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL xor_in_ready[%0d] got %b exp 0", i, in_ready); end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL xor_release_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL xor_idle got %b exp 0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL xor_idle_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_nand_gaps();
    out_ready = 1'b1;
    send(8'hFF, GATE_NAND);
    tick();
    send(8'hFF, GATE_NAND);
    tick();
    tick();
    send(8'hFF, GATE_NAND);
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nand_gap_valid got %b exp 0", out_valid); end
    send(8'h7F, GATE_NAND);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nand_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 8'h80) begin errors++; $display("FAIL nand_data got %h exp 80", out_data); end
    tick();
  endtask

  task automatic test_reserved();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'hAA, 3'd7);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rsv_valid got %b exp 1", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rsv_data got %h exp 00", out_data); end
    checks++; if (out_err !== 1'b1) begin errors++; $display("FAIL rsv_err got %b exp 1", out_err); end
    tick();
    send(8'h01, GATE_OR);
    send(8'h10, GATE_OR);
    send(8'h00, GATE_OR);
    send(8'h80, GATE_OR);
    checks++; if (out_data !== 8'h91) begin errors++; $display("FAIL or_data got %h exp 91", out_data); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL or_err got %b exp 0", out_err); end
    tick();
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    send(8'h00, GATE_AND);
    send(8'h00, GATE_AND);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy); end
    send(8'hF3, GATE_AND);
    send(8'h3F, GATE_AND);
    send(8'hFF, GATE_AND);
    send(8'hFF, GATE_AND);
    checks++; if (out_data !== 8'h33) begin errors++; $display("FAIL abort_and_data got %h exp 33", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_and_valid got %b exp 1", out_valid); end
    tick();
    // Abort on the same edge as the final beat
    send(8'h01, GATE_OR);
    send(8'h02, GATE_OR);
    send(8'h04, GATE_OR);
    abort = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_ready got %b exp 0", in_ready); end
    send(8'h08, GATE_OR);
    abort = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_last_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_last_busy got %b exp 0", busy); end
    // Abort drops a pending result in DONE
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'h0F, GATE_XNOR);
    checks++; if (out_data !== 8'hFF) begin errors++; $display("FAIL xnor_data got %h exp ff", out_data); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_done_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_done_busy got %b exp 0", busy); end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send(8'hFF, GATE_AND);
    send(8'hFF, GATE_AND);
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b exp 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    rst_n = 1'b1;
    send(8'h01, GATE_OR);
    send(8'h02, GATE_OR);
    send(8'h04, GATE_OR);
    send(8'h08, GATE_OR);
    checks++; if (out_data !== 8'h0F) begin errors++; $display("FAIL rstmid_or_data got %h exp 0f", out_data); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_or_valid got %b exp 1", out_valid); end
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 3'd0;
    abort     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    test_reset();
    test_nor();
    test_xor_backpressure();
    test_nand_gaps();
    test_reserved();
    test_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
